// File: rtl/pacman_game_pkg.sv
// Shared definitions for the PacMan round sequencer: tile codes and FSM encodings.
package pacman_game_pkg;

  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_FOOD  = 4'd1;
  localparam logic [3:0] TILE_POWER = 4'd2;
  localparam logic [3:0] TILE_WALL  = 4'd3;

  typedef enum logic [3:0] {
    S_LOAD,
    S_READY,
    S_WAIT_TICK,
    S_MOVE,
    S_RESOLVE,
    S_WRITE,
    S_COMMIT,
    S_RESPAWN,
    S_END
  } state_t;

  // Where WRITE goes once the board writer reports done.
  typedef enum logic [1:0] {
    EXIT_COMMIT,
    EXIT_RESPAWN,
    EXIT_LOSE,
    EXIT_WIN
  } exit_t;

endpackage

// File: rtl/game_round_controller_mover_sync.sv
// Collects done reports from all movers (sticky per channel) and runs the move watchdog.
// clr is held high whenever the movers are not being waited on and on the first
// MOVE cycle, so a done arriving together with the start pulse is still captured.
module mover_sync #(
  parameter int N       = 5,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [N-1:0] done,
  output logic         all_done,
  output logic         timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [N-1:0]  doneSeen;
  logic [N-1:0]  doneNow;
  logic [CW-1:0] waitCnt;

  // On clr the old round's latches are discarded but this cycle's dones still count.
  assign doneNow  = clr ? done : (doneSeen | done);
  assign all_done = &doneNow;
  // waitCnt holds the number of MOVE cycles already finished; fire on the last allowed one.
  assign timeout  = clr ? (TIMEOUT <= 1) : (waitCnt >= CW'(TIMEOUT - 1));

  // Sticky done bits and saturating cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      doneSeen <= '0;
      waitCnt  <= '0;
    end else begin
      doneSeen <= doneNow;
      if (clr) begin
        waitCnt <= CW'(1);
      end else if (waitCnt != CW'(TIMEOUT)) begin
        waitCnt <= waitCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// PacMan round sequencer: per tick runs move, resolve and write phases, then commits
// positions. Tracks food, lives, frightened mode and a mover watchdog.
module game_round_controller
  import pacman_game_pkg::*;
#(
  parameter int NUM_GHOSTS   = 4,
  parameter int ADDR_W       = 10,
  parameter int NUM_FOOD     = 100,
  parameter int NUM_LIVES    = 3,
  parameter int FRIGHT_TICKS = 20,
  parameter int MOVE_TIMEOUT = 255,
  parameter int PAC_HOME     = 495,
  parameter int GHOST_HOME   = 366
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_game,
  input  logic                         play_again,
  input  logic                         tick,
  output logic                         move_start,
  input  logic                         pac_done,
  input  logic [NUM_GHOSTS-1:0]        ghost_done,
  input  logic [ADDR_W-1:0]            pac_next,
  input  logic [NUM_GHOSTS*ADDR_W-1:0] ghost_next,
  input  logic [3:0]                   tile_at_next,
  output logic                         wr_start,
  input  logic                         wr_done,
  output logic [ADDR_W-1:0]            pac_pos,
  output logic [NUM_GHOSTS*ADDR_W-1:0] ghost_pos,
  output logic                         ready,
  output logic                         game_over,
  output logic                         user_won,
  output logic                         stall_err,
  output logic [$clog2(NUM_LIVES+1)-1:0] lives,
  output logic [$clog2(NUM_FOOD+1)-1:0]  food_count,
  output logic                         fright
);

  localparam int LW = $clog2(NUM_LIVES + 1);
  localparam int FW = $clog2(NUM_FOOD + 1);
  localparam int TW = $clog2(FRIGHT_TICKS + 1);
  localparam logic [ADDR_W-1:0] PAC_HOME_A   = ADDR_W'(PAC_HOME);
  localparam logic [ADDR_W-1:0] GHOST_HOME_A = ADDR_W'(GHOST_HOME);

  state_t stateReg, stateNext;
  logic   entryReg;
  exit_t  exitReg;

  logic [ADDR_W-1:0]     pacPosReg;
  logic [ADDR_W-1:0]     ghostPosReg [NUM_GHOSTS];
  logic [ADDR_W-1:0]     ghostNext   [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] hit;
  logic [NUM_GHOSTS-1:0] markReg;
  logic [LW-1:0]         livesReg;
  logic [FW-1:0]         foodReg;
  logic [TW-1:0]         frightCnt;
  logic                  frightLoaded;
  logic                  wonReg;
  logic                  stallReg;

  logic        moverClr, moversDone, moverTimeout;
  logic        eatTile, isPower, anyHit, frightOn, winNow;
  logic [FW:0] foodSum;

  assign frightOn = (frightCnt != '0);
  assign isPower  = (tile_at_next == TILE_POWER);
  assign eatTile  = (tile_at_next == TILE_FOOD) || isPower;
  assign foodSum  = {1'b0, foodReg} + {{FW{1'b0}}, eatTile};
  assign winNow   = (foodSum == (FW+1)'(NUM_FOOD));
  assign anyHit   = |hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
      assign ghostNext[gi] = ghost_next[gi*ADDR_W +: ADDR_W];
      // Same target tile, or pacman and ghost swap tiles through each other.
      assign hit[gi] = (pac_next == ghostNext[gi]) ||
                       ((pac_next == ghostPosReg[gi]) && (ghostNext[gi] == pacPosReg));
      assign ghost_pos[gi*ADDR_W +: ADDR_W] = ghostPosReg[gi];

      // Ghost position: home on load/respawn, proposed tile (or home if eaten) at commit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ghostPosReg[gi] <= GHOST_HOME_A;
        end else if (stateReg == S_LOAD || stateReg == S_RESPAWN) begin
          ghostPosReg[gi] <= GHOST_HOME_A;
        end else if (stateReg == S_COMMIT) begin
          ghostPosReg[gi] <= markReg[gi] ? GHOST_HOME_A : ghostNext[gi];
        end
      end
    end
  endgenerate

  assign moverClr = (stateReg != S_MOVE) || entryReg;

  mover_sync #(
    .N       (NUM_GHOSTS + 1),
    .TIMEOUT (MOVE_TIMEOUT)
  ) uMoverSync (
    .clk      (clk),
    .reset    (reset),
    .clr      (moverClr),
    .done     ({ghost_done, pac_done}),
    .all_done (moversDone),
    .timeout  (moverTimeout)
  );

  // State register plus a flag marking the first cycle spent in a state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= S_LOAD;
      entryReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      entryReg <= (stateNext != stateReg);
    end
  end

  // Next-state selection.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_LOAD:      stateNext = S_READY;
      S_READY:     if (start_game) stateNext = S_WAIT_TICK;
      S_WAIT_TICK: if (tick) stateNext = S_MOVE;
      S_MOVE: begin
        if (moversDone)        stateNext = S_RESOLVE;
        else if (moverTimeout) stateNext = S_END;
      end
      S_RESOLVE:   stateNext = S_WRITE;
      S_WRITE: begin
        if (wr_done) begin
          case (exitReg)
            EXIT_COMMIT:  stateNext = S_COMMIT;
            EXIT_RESPAWN: stateNext = S_RESPAWN;
            default:      stateNext = S_END;
          endcase
        end
      end
      S_COMMIT,
      S_RESPAWN:   stateNext = S_WAIT_TICK;
      S_END:       if (play_again) stateNext = S_LOAD;
      default:     stateNext = S_LOAD;
    endcase
  end

  // Round bookkeeping: food, lives, fright timer, exit decision and sticky end flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pacPosReg    <= PAC_HOME_A;
      livesReg     <= LW'(NUM_LIVES);
      foodReg      <= '0;
      frightCnt    <= '0;
      frightLoaded <= 1'b0;
      markReg      <= '0;
      exitReg      <= EXIT_COMMIT;
      wonReg       <= 1'b0;
      stallReg     <= 1'b0;
    end else begin
      case (stateReg)
        S_LOAD: begin
          pacPosReg    <= PAC_HOME_A;
          livesReg     <= LW'(NUM_LIVES);
          foodReg      <= '0;
          frightCnt    <= '0;
          frightLoaded <= 1'b0;
          markReg      <= '0;
          exitReg      <= EXIT_COMMIT;
          wonReg       <= 1'b0;
          stallReg     <= 1'b0;
        end
        S_MOVE: begin
          if (!moversDone && moverTimeout) stallReg <= 1'b1;
        end
        S_RESOLVE: begin
          if (eatTile && foodReg != FW'(NUM_FOOD)) foodReg <= foodSum[FW-1:0];
          frightLoaded <= isPower;
          if (isPower) frightCnt <= TW'(FRIGHT_TICKS);
          markReg <= '0;
          // frightOn is the pre-load value, so a pellet eaten onto a ghost still costs a life.
          if (winNow) begin
            exitReg <= EXIT_WIN;
          end else if (anyHit && !frightOn) begin
            livesReg <= livesReg - LW'(1);
            exitReg  <= (livesReg == LW'(1)) ? EXIT_LOSE : EXIT_RESPAWN;
          end else begin
            exitReg <= EXIT_COMMIT;
            markReg <= hit;
          end
        end
        S_WRITE: begin
          if (wr_done && exitReg == EXIT_WIN) wonReg <= 1'b1;
        end
        S_COMMIT: begin
          pacPosReg    <= pac_next;
          frightLoaded <= 1'b0;
          if (frightOn && !frightLoaded) frightCnt <= frightCnt - TW'(1);
        end
        S_RESPAWN: begin
          pacPosReg    <= PAC_HOME_A;
          frightCnt    <= '0;
          frightLoaded <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign move_start = (stateReg == S_MOVE) && entryReg;
  assign wr_start   = (stateReg == S_WRITE) && entryReg;
  assign ready      = (stateReg == S_READY);
  assign game_over  = (stateReg == S_END);
  assign user_won   = wonReg;
  assign stall_err  = stallReg;
  assign pac_pos    = pacPosReg;
  assign lives      = livesReg;
  assign food_count = foodReg;
  assign fright     = frightOn;

endmodule
